// File: rtl/led_activity_driver.sv
// LED output conditioner: per-channel level passthrough or pulse stretch, shared PWM dimming.
// Optional blinking stretch tail when LED_ACTIVITY_DRIVER_BLINK_EN is defined.
module led_activity_driver #(
    parameter int WIDTH    = 8,
    parameter int RATE     = 125000,
    parameter int STRETCH  = 50,
    parameter int PWM_BITS = 4,
    parameter int BLINK    = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in,
    input  logic [WIDTH-1:0]    mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [WIDTH-1:0]    out
);

    localparam int                PW         = $clog2(RATE);
    localparam logic [PW-1:0]     PRESC_LAST = PW'(RATE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [15:0]       STRETCH_LD = 16'(STRETCH);

    if (RATE < 2 || STRETCH < 1 || STRETCH > 65535 || BLINK < 1) begin : g_param_check
        $error("led_activity_driver: parameter out of range");
    end

    logic [PW-1:0]       r_presc;
    logic [PWM_BITS-1:0] r_pwm;
    logic [WIDTH-1:0]    r_in;
    logic [WIDTH-1:0]    r_out;
    logic [15:0]         r_cnt [WIDTH];

    logic                w_tick;
    logic                w_pwm_en;
    logic [WIDTH-1:0]    w_live;
    logic [WIDTH-1:0]    w_tail;
    logic [WIDTH-1:0]    w_on;

    assign w_tick   = (r_presc == PRESC_LAST);
    // The top PWM code never falls below pwm_cnt's maximum, so all-ones means always on.
    assign w_pwm_en = (r_pwm < brightness);

    // NOTE: default first in always_comb so no path leaves a bit unassigned (no latch).
    always_comb begin
        w_live = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_live[i] = (r_cnt[i] != '0);
        end
    end

`ifdef LED_ACTIVITY_DRIVER_BLINK_EN
    localparam int           BW         = (BLINK > 1) ? $clog2(BLINK) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_tail = w_live & {WIDTH{r_phase}};
`else
    assign w_tail = w_live;
`endif

    // A live input always forces steady on; the tail only matters in stretch mode.
    assign w_on = r_in | (mode & w_tail);

    // NOTE: every state register, including the stretch counter array, is cleared by rst
    // so a reset during an active stretch drops the LED on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
            r_in    <= '0;
            r_out   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_pwm   <= (r_pwm == PWM_LAST) ? '0 : r_pwm + 1'b1;
            r_in    <= in;
            r_out   <= w_on & {WIDTH{w_pwm_en}};
            for (int i = 0; i < WIDTH; i++) begin
                if (r_in[i]) begin
                    r_cnt[i] <= STRETCH_LD;
                end else if (w_tick && w_live[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign out = r_out;

endmodule
